vga_timing_monitor: RTL and testbench

//  Receive-side counterpart of the 800x600@72Hz VGA timing generator. Samples incoming

---
 rtl/vga_timing_monitor.sv | 251 +++++++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_monitor
// Purpose  : Measures incoming VGA HS/VS timing against the 800x600@72Hz mode.
//            Once locked, it recovers the pixel position and data-enable.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_monitor #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_TOTAL     = 1040,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_TOTAL     = 666,
    parameter int TOL         = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    output logic        locked,
    output logic        mode_err,
    output logic        frame_start,
    output logic [11:0] meas_h_period,
    output logic [11:0] meas_h_sync,
    output logic [10:0] meas_v_lines,
    output logic [10:0] meas_v_sync,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        de
);

    localparam logic [11:0] c_per_min  = 12'(H_TOTAL - TOL);
    localparam logic [11:0] c_per_max  = 12'(H_TOTAL + TOL);
    localparam logic [11:0] c_wid_min  = 12'(H_SYNC - TOL);
    localparam logic [11:0] c_wid_max  = 12'(H_SYNC + TOL);
    localparam logic [11:0] c_timeout  = 12'(2 * H_TOTAL + 1);
    localparam logic [10:0] c_v_total  = 11'(V_TOTAL);
    localparam logic [10:0] c_v_sync   = 11'(V_SYNC);
    localparam logic [10:0] c_x_start  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_x_last   = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
    localparam logic [9:0]  c_y_start  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_y_last   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  c_v_active = 10'(V_ACTIVE);
    localparam logic [7:0]  c_lock     = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_good, w_good_nxt;
    logic        r_frame_bad, w_bad_nxt, w_err;

    logic        r_hs_s1, r_hs_s2, r_hs_s3;
    logic        r_vs_s1, r_vs_s2, r_vs_s3;
    logic [11:0] r_h_cnt, r_s_cnt;
    logic [10:0] r_l_cnt, r_v_cnt;
    logic [10:0] r_px;
    logic [9:0]  r_py;
    logic        r_locked, r_mode_err, r_frame_start;
    logic [11:0] r_meas_h_period, r_meas_h_sync;
    logic [10:0] r_meas_v_lines, r_meas_v_sync;

    logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_low;
    logic [11:0] w_h_inc, w_s_inc;
    logic [10:0] w_l_inc, w_v_inc;
    logic        w_per_ok, w_wid_ok, w_v_ok, w_timeout;
    logic        w_line_fail, w_frame_fail, w_x_wrap;

    // Third flop of each chain is the edge reference for the synchronized level
    assign w_hs_fall = r_hs_s3 & ~r_hs_s2;
    assign w_hs_rise = ~r_hs_s3 & r_hs_s2;
    assign w_vs_fall = r_vs_s3 & ~r_vs_s2;
    assign w_vs_low  = ~r_vs_s2;

    assign w_h_inc = (r_h_cnt == 12'hFFF) ? r_h_cnt : r_h_cnt + 12'd1;
    assign w_s_inc = (r_s_cnt == 12'hFFF) ? r_s_cnt : r_s_cnt + 12'd1;
    assign w_l_inc = (r_l_cnt == 11'h7FF) ? r_l_cnt : r_l_cnt + 11'd1;
    assign w_v_inc = (r_v_cnt == 11'h7FF) ? r_v_cnt : r_v_cnt + 11'd1;

    assign w_per_ok     = (w_h_inc >= c_per_min) && (w_h_inc <= c_per_max);
    assign w_wid_ok     = (w_s_inc >= c_wid_min) && (w_s_inc <= c_wid_max);
    assign w_v_ok       = (r_l_cnt == c_v_total) && (r_v_cnt == c_v_sync);
    assign w_timeout    = (r_h_cnt == c_timeout) && !w_hs_fall;
    assign w_line_fail  = (w_hs_fall && !w_per_ok) || (w_hs_rise && !w_wid_ok);
    assign w_frame_fail = w_vs_fall && !w_v_ok;
    assign w_x_wrap     = (r_px == c_x_last);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_hs_s1 <= 1'b0;
            r_hs_s2 <= 1'b0;
            r_hs_s3 <= 1'b0;
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_s3 <= 1'b0;
        end else begin
            r_hs_s1 <= VGA_HS;
            r_hs_s2 <= r_hs_s1;
            r_hs_s3 <= r_hs_s2;
            r_vs_s1 <= VGA_VS;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
        end
    end

    // A frame boundary that coincides with an HS fall counts that line in the new frame
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_h_cnt         <= '0;
            r_s_cnt         <= '0;
            r_l_cnt         <= '0;
            r_v_cnt         <= '0;
            r_meas_h_period <= '0;
            r_meas_h_sync   <= '0;
            r_meas_v_lines  <= '0;
            r_meas_v_sync   <= '0;
        end else begin
            r_h_cnt <= w_hs_fall ? 12'd0 : w_h_inc;
            r_s_cnt <= w_hs_fall ? 12'd0 : w_s_inc;
            if (w_hs_fall)
                r_meas_h_period <= w_h_inc;
            if (w_hs_rise)
                r_meas_h_sync <= w_s_inc;
            if (w_vs_fall) begin
                r_meas_v_lines <= r_l_cnt;
                r_meas_v_sync  <= r_v_cnt;
                r_l_cnt        <= w_hs_fall ? 11'd1 : 11'd0;
                r_v_cnt        <= (w_hs_fall && w_vs_low) ? 11'd1 : 11'd0;
            end else begin
                if (w_hs_fall)
                    r_l_cnt <= w_l_inc;
                if (w_hs_fall && w_vs_low)
                    r_v_cnt <= w_v_inc;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_SEARCH;
            r_good        <= '0;
            r_frame_bad   <= 1'b0;
            r_locked      <= 1'b0;
            r_mode_err    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_good        <= w_good_nxt;
            r_frame_bad   <= w_bad_nxt;
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_mode_err    <= w_err;
            r_frame_start <= w_vs_fall;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_frame_bad;
        w_err       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                    w_bad_nxt   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (w_vs_fall) begin
                    w_bad_nxt = 1'b0;
                    if (w_frame_fail || w_line_fail) begin
                        w_err      = 1'b1;
                        w_good_nxt = '0;
                    end else if (r_frame_bad) begin
                        w_good_nxt = '0;
                    end else if (r_good + 8'd1 >= c_lock) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good + 8'd1;
                    end
                end else if (w_line_fail) begin
                    w_err      = 1'b1;
                    w_good_nxt = '0;
                    w_bad_nxt  = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_frame_fail || w_line_fail) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                    w_bad_nxt   = !w_vs_fall;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = '0;
                w_bad_nxt   = 1'b0;
            end
        endcase
        // A lost HS overrides everything; the counter passes this value only once per stall
        if (w_timeout) begin
            w_err       = 1'b1;
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
            w_bad_nxt   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_px <= '0;
            r_py <= '0;
        end else begin
            if (w_hs_fall)
                r_px <= c_x_start;
            else if (w_x_wrap)
                r_px <= '0;
            else
                r_px <= r_px + 11'd1;

            if (w_vs_fall)
                r_py <= c_y_start;
            else if (!w_hs_fall && w_x_wrap)
                r_py <= (r_py == c_y_last) ? 10'd0 : r_py + 10'd1;
        end
    end

    assign locked        = r_locked;
    assign mode_err      = r_mode_err;
    assign frame_start   = r_frame_start;
    assign meas_h_period = r_meas_h_period;
    assign meas_h_sync   = r_meas_h_sync;
    assign meas_v_lines  = r_meas_v_lines;
    assign meas_v_sync   = r_meas_v_sync;
    assign pixel_x       = r_locked ? r_px : 11'd0;
    assign pixel_y       = r_locked ? r_py : 10'd0;
    assign de            = r_locked && (r_px < c_h_active) && (r_py < c_v_active);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_monitor
// Purpose  : Directed bench for vga_timing_monitor on a scaled-down raster
//            (32x16 total, 20x10 active) with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_monitor;

    localparam int c_ha  = 20;
    localparam int c_hfp = 4;
    localparam int c_hs  = 6;
    localparam int c_ht  = 32;
    localparam int c_va  = 10;
    localparam int c_vfp = 2;
    localparam int c_vs  = 2;
    localparam int c_vt  = 16;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        VGA_HS   = 1'b1;
    logic        VGA_VS   = 1'b1;
    logic        locked, mode_err, frame_start, de;
    logic [11:0] meas_h_period, meas_h_sync;
    logic [10:0] meas_v_lines, meas_v_sync, pixel_x;
    logic [9:0]  pixel_y;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_err  = 0;
    int   n_fs   = 0;
    int   de_acc = 0;
    int   last_de = 0;
    int   de_bad = 0;
    logic fs_locked   = 1'b0;
    logic fs_prev     = 1'b0;
    logic prev_locked = 1'b0;

    vga_timing_monitor #(
        .H_ACTIVE(c_ha), .H_FP(c_hfp), .H_SYNC(c_hs), .H_TOTAL(c_ht),
        .V_ACTIVE(c_va), .V_FP(c_vfp), .V_SYNC(c_vs), .V_TOTAL(c_vt),
        .TOL(2), .LOCK_FRAMES(2)
    ) u_dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .locked       (locked),
        .mode_err     (mode_err),
        .frame_start  (frame_start),
        .meas_h_period(meas_h_period),
        .meas_h_sync  (meas_h_sync),
        .meas_v_lines (meas_v_lines),
        .meas_v_sync  (meas_v_sync),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .de           (de)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: event counts plus per-cycle raster consistency
    always @(posedge CLOCK_50) begin
        #1;
        if (!RESET) begin
            if (mode_err)
                n_err++;
            if (frame_start) begin
                n_fs++;
                fs_locked = locked;
                fs_prev   = prev_locked;
                last_de   = de_acc;
                de_acc    = 0;
                if (locked) begin
                    chk("px_at_vs", 32'(pixel_x), 32'(c_ha + c_hfp));
                    chk("py_at_vs", 32'(pixel_y), 32'(c_va + c_vfp));
                end
            end
            if (de)
                de_acc++;
            if (locked) begin
                if (de !== ((pixel_x < 11'(c_ha)) && (pixel_y < 10'(c_va))))
                    de_bad++;
                if (pixel_x >= 11'(c_ht) || pixel_y >= 10'(c_vt))
                    de_bad++;
            end else if (de !== 1'b0 || pixel_x != 11'd0 || pixel_y != 10'd0) begin
                de_bad++;
            end
            prev_locked = locked;
        end
    end

    task automatic run_line(input int per, input int wid, input bit vs_low);
        for (int t = 0; t < per; t++) begin
            @(negedge CLOCK_50);
            VGA_HS = (t < wid) ? 1'b0 : 1'b1;
            if (t == 0)
                VGA_VS = vs_low ? 1'b0 : 1'b1;
        end
    endtask

    task automatic run_lines(input int first, input int last, input int odd_line,
                             input int odd_per, input int odd_wid, input int vs_lines);
        for (int l = first; l <= last; l++) begin
            if (l == odd_line)
                run_line(odd_per, odd_wid, l < vs_lines);
            else
                run_line(c_ht, c_hs, l < vs_lines);
        end
    endtask

    task automatic run_frame(input int odd_line, input int odd_per, input int odd_wid,
                             input int vs_lines);
        run_lines(0, c_vt - 1, odd_line, odd_per, odd_wid, vs_lines);
    endtask

    task automatic good_frame();
        run_frame(-1, c_ht, c_hs, c_vs);
    endtask

    task automatic chk_meas_nominal(input string tag);
        chk({tag, "_hper"}, 32'(meas_h_period), 32'(c_ht));
        chk({tag, "_hsync"}, 32'(meas_h_sync), 32'(c_hs));
        chk({tag, "_vlines"}, 32'(meas_v_lines), 32'(c_vt));
        chk({tag, "_vsync"}, 32'(meas_v_sync), 32'(c_vs));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_mode_err"}, 32'(mode_err), 0);
        chk({tag, "_fstart"}, 32'(frame_start), 0);
        chk({tag, "_hper"}, 32'(meas_h_period), 0);
        chk({tag, "_hsync"}, 32'(meas_h_sync), 0);
        chk({tag, "_vlines"}, 32'(meas_v_lines), 0);
        chk({tag, "_vsync"}, 32'(meas_v_sync), 0);
        chk({tag, "_px"}, 32'(pixel_x), 0);
        chk({tag, "_py"}, 32'(pixel_y), 0);
        chk({tag, "_de"}, 32'(de), 0);
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk_all_zero("rst");
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        // Acquire lock from reset: lock rises with the third frame start
        good_frame();
        good_frame();
        chk("fs2_locked", 32'(fs_locked), 0);
        good_frame();
        chk("fs3_count", 32'(n_fs), 3);
        chk("fs3_locked", 32'(fs_locked), 1);
        chk("fs3_prev_locked", 32'(fs_prev), 0);
        chk_meas_nominal("acq");
        chk("acq_no_err", 32'(n_err), 0);

        // One locked frame: active area is 20x10
        good_frame();
        good_frame();
        chk("de_per_frame", 32'(last_de), 32'(c_ha * c_va));

        // Period out of tolerance (+3): one error, relock after two clean frames
        base = n_err;
        run_frame(8, c_ht + 3, c_hs, c_vs);
        chk("hlong_err", 32'(n_err - base), 1);
        chk("hlong_unlock", 32'(locked), 0);
        good_frame();
        good_frame();
        chk("hlong_not_yet", 32'(locked), 0);
        good_frame();
        chk("hlong_relock", 32'(locked), 1);
        chk("hlong_err_once", 32'(n_err - base), 1);

        // Edges of tolerance band are accepted
        base = n_err;
        run_frame(c_vt - 1, c_ht + 1, c_hs - 2, c_vs);
        chk("tol_wid_lo", 32'(meas_h_sync), 32'(c_hs - 2));
        run_frame(c_vt - 1, c_ht - 2, c_hs + 2, c_vs);
        chk("tol_wid_hi", 32'(meas_h_sync), 32'(c_hs + 2));
        good_frame();
        chk("tol_no_err", 32'(n_err - base), 0);
        chk("tol_locked", 32'(locked), 1);

        // HS width just outside tolerance
        base = n_err;
        run_frame(c_vt - 1, c_ht, c_hs + 3, c_vs);
        chk("wid_meas", 32'(meas_h_sync), 32'(c_hs + 3));
        chk("wid_err", 32'(n_err - base), 1);
        chk("wid_unlock", 32'(locked), 0);
        good_frame();
        good_frame();
        chk("wid_not_yet", 32'(locked), 0);
        good_frame();
        chk("wid_relock", 32'(locked), 1);

        // Vertical sync one line too long: flagged at the next frame start
        base = n_err;
        run_frame(-1, c_ht, c_hs, c_vs + 1);
        good_frame();
        chk("vs_err", 32'(n_err - base), 1);
        chk("vs_meas", 32'(meas_v_sync), 32'(c_vs + 1));
        chk("vs_unlock", 32'(locked), 0);
        good_frame();
        chk("vs_not_yet", 32'(locked), 0);
        good_frame();
        chk("vs_relock", 32'(locked), 1);

        // HS stall: single timeout error, measurements held, back to search
        base = n_err;
        repeat (4100) @(negedge CLOCK_50);
        chk("to_err_once", 32'(n_err - base), 1);
        chk("to_unlock", 32'(locked), 0);
        chk_meas_nominal("to_held");
        run_lines(0, 0, -1, c_ht, c_hs, c_vs);
        chk("to_hper_sat", 32'(meas_h_period), 4095);
        run_lines(1, c_vt - 1, -1, c_ht, c_hs, c_vs);
        good_frame();
        chk("to_search_2nd", 32'(locked), 0);
        good_frame();
        chk("to_relock", 32'(locked), 1);
        chk("to_no_more_err", 32'(n_err - base), 1);

        // Asynchronous reset mid-frame while locked
        base = n_err;
        run_lines(0, 6, -1, c_ht, c_hs, c_vs);
        chk("pre_rst_locked", 32'(locked), 1);
        #3 RESET = 1'b1;
        #1;
        chk_all_zero("arst");
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        run_lines(7, c_vt - 1, -1, c_ht, c_hs, c_vs);
        good_frame();
        good_frame();
        chk("arst_not_yet", 32'(locked), 0);
        good_frame();
        chk("arst_relock", 32'(locked), 1);
        chk("arst_no_err", 32'(n_err - base), 0);

        chk("raster_consistency", 32'(de_bad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
